pmem_scheduler: RTL
===================

PMEM_SCHEDULER -- requirements
Module: pmem_scheduler

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive D-cache grants while an I-cache request waits.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 icache_pmem_read  input  1  I-cache block read request, held until icache_mem_resp.
REQ-005 icache_pmem_address  input  16  I-cache block address.
REQ-006 icache_mem_rdata  output  256  block returned to I-cache.
REQ-007 icache_mem_resp  output  1  I-cache transaction complete.
REQ-008 dcache_pmem_read / dcache_pmem_write  input  1 each  D-cache block read / write-back request, held until dcache_mem_resp.
REQ-009 dcache_pmem_address  input  16  D-cache block address.
REQ-010 dcache_pmem_wdata  input  256  D-cache write-back block.
REQ-011 dcache_mem_rdata  output  256  block returned to D-cache.
REQ-012 dcache_mem_resp  output  1  D-cache transaction complete.
REQ-013 l2_pmem_read / l2_pmem_write  output  1 each  request to L2 cache.
REQ-014 l2_pmem_address  output  16; l2_pmem_wdata  output  256  latched address and write data to L2.
REQ-015 l2_pmem_resp  input  1; l2_pmem_rdata  input  256  L2 completion and read data.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT_I, GRANT_D, RELEASE.
REQ-017 In IDLE with any request pending, the grant SHALL register on the next edge; l2 read/write asserts the cycle after the request is first seen (1-cycle grant latency).
REQ-018 Default priority SHALL be D over I.
REQ-019 A 3-bit starvation counter SHALL increment on each D grant made while icache_pmem_read is high, saturate at STARVE_LIMIT, and clear on any I grant.
REQ-020 When the counter equals STARVE_LIMIT and both request, I SHALL be granted.
REQ-021 At grant, address (and wdata for D write) SHALL be latched into registers driving l2_pmem_address/l2_pmem_wdata; requester input changes during grant SHALL be ignored.
REQ-022 D request with both read and write high SHALL be serviced as a write.
REQ-023 l2_pmem_read/write SHALL stay asserted from grant until the cycle l2_pmem_resp is high, inclusive.
REQ-024 l2_pmem_resp SHALL be forwarded combinationally to the granted requester's resp only; the non-granted resp SHALL be 0.
REQ-025 l2_pmem_rdata SHALL be forwarded combinationally to both rdata outputs; only the granted resp qualifies it.
REQ-026 On l2_pmem_resp the FSM SHALL go to RELEASE for exactly one cycle (all l2 requests low, no resp), then IDLE.
REQ-027 l2_pmem_read and l2_pmem_write SHALL never be high simultaneously.

Reset
REQ-028 reset SHALL immediately force IDLE, counter 0, latched address/wdata 0, l2 read/write 0, both resp 0, including mid-transaction.
REQ-029 After reset deassertion, held requests SHALL be arbitrated as fresh IDLE requests.

Structure
REQ-030 lc3b_word (16-bit) and lc3b_block (256-bit) SHALL come from package lc3b_types; the state enum SHALL be local.
REQ-031 The starvation counter SHALL be a sub-module named starve_counter (increment, clear, saturate at parameter).

Verification
REQ-032 I read only, addr 0x0040, L2 resp after 5 cycles, rdata all-0xA5 -> l2_pmem_read high cycles 1-6, icache_mem_resp one cycle with rdata 0xA5..., dcache_mem_resp 0.
REQ-033 I read 0x0100 and D write 0x0200 same cycle -> D first (l2_pmem_write, address 0x0200), RELEASE, then I read 0x0100.
REQ-034 I held high, D re-requests continuously -> exactly 4 D grants, then I granted, counter returns to 0.
REQ-035 D read+write both high, addr 0x1234 -> l2_pmem_write only, wdata equals dcache_pmem_wdata sampled at grant.
REQ-036 reset pulsed during GRANT_D before l2 resp -> all outputs 0 immediately, IDLE; held request re-granted 1 cycle after reset release.
REQ-037 Change dcache_pmem_address 0x0200->0x0300 mid-grant -> l2_pmem_address stays 0x0200 until resp.

Source files
------------

// File: rtl/lc3b_types.sv
// lc3b_types
//   Shared LC-3b memory-system types: a 16-bit word used for block
//   addresses and a 256-bit cache block. Also holds the width of the
//   starvation counter used by the physical-memory scheduler.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_block;

  // Width of the I-cache starvation counter.
  localparam int unsigned STARVE_CNT_W = 3;

endpackage : lc3b_types

// File: rtl/pmem_scheduler_starve_counter.sv
// starve_counter
//   Counts consecutive D-cache grants made while the I-cache is waiting.
//   Saturates at LIMIT; a clear has priority over an increment.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset (count -> 0)
//   inc    in   count one more D grant made while I waits
//   clr    in   an I grant was made; restart from zero
//   count  out  current count
module starve_counter
  import lc3b_types::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inc,
  input  logic                    clr,
  output logic [STARVE_CNT_W-1:0] count
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] count_q;
  logic [STARVE_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q < LIMIT_C)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : starve_counter

// File: rtl/pmem_scheduler.sv
// pmem_scheduler
//   Arbitrates the I-cache and D-cache for a single L2 port. D-cache has
//   priority unless the I-cache has been passed over STARVE_LIMIT times in
//   a row. Address and write data are captured at grant, so requesters may
//   change their inputs while a transaction is in flight. Every
//   transaction ends with one RELEASE cycle in which nothing is driven.
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   icache_pmem_read/_address          I-cache block read request
//   icache_mem_rdata/_resp             I-cache return data / completion
//   dcache_pmem_read/_write/_address   D-cache block read / write-back request
//   dcache_pmem_wdata                  D-cache write-back block
//   dcache_mem_rdata/_resp             D-cache return data / completion
//   l2_pmem_read/_write                request to L2 (never both high)
//   l2_pmem_address/_wdata             latched address / write data to L2
//   l2_pmem_resp/_rdata                L2 completion / read data
module pmem_scheduler
  import lc3b_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      reset,

  input  logic      icache_pmem_read,
  input  lc3b_word  icache_pmem_address,
  output lc3b_block icache_mem_rdata,
  output logic      icache_mem_resp,

  input  logic      dcache_pmem_read,
  input  logic      dcache_pmem_write,
  input  lc3b_word  dcache_pmem_address,
  input  lc3b_block dcache_pmem_wdata,
  output lc3b_block dcache_mem_rdata,
  output logic      dcache_mem_resp,

  output logic      l2_pmem_read,
  output logic      l2_pmem_write,
  output lc3b_word  l2_pmem_address,
  output lc3b_block l2_pmem_wdata,
  input  logic      l2_pmem_resp,
  input  lc3b_block l2_pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  state_e    state_q, state_d;
  lc3b_word  addr_q, addr_d;
  lc3b_block wdata_q, wdata_d;
  logic      is_write_q, is_write_d;

  logic                    cnt_inc;
  logic                    cnt_clr;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    d_req;
  logic                    i_wins;

  assign d_req  = dcache_pmem_read | dcache_pmem_write;
  // I wins when D is idle, or when I has been passed over too often.
  assign i_wins = icache_pmem_read && (!d_req || (starve_cnt == LIMIT_C));

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .count (starve_cnt)
  );

  // Next-state / capture logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_wins) begin
          state_d    = GRANT_I;
          addr_d     = icache_pmem_address;
          is_write_d = 1'b0;
          cnt_clr    = 1'b1;
        end else if (d_req) begin
          state_d    = GRANT_D;
          addr_d     = dcache_pmem_address;
          // Read+write together is a write-back.
          is_write_d = dcache_pmem_write;
          if (dcache_pmem_write) begin
            wdata_d = dcache_pmem_wdata;
          end
          cnt_inc    = icache_pmem_read;
        end
      end
      GRANT_I, GRANT_D: begin
        if (l2_pmem_resp) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
    end
  end

  // Outputs: L2 op is held for the whole grant; is_write_q is 0 for an
  // I grant, so read and write can never overlap.
  always_comb begin
    l2_pmem_read    = 1'b0;
    l2_pmem_write   = 1'b0;
    icache_mem_resp = 1'b0;
    dcache_mem_resp = 1'b0;
    if ((state_q == GRANT_I) || (state_q == GRANT_D)) begin
      l2_pmem_read  = ~is_write_q;
      l2_pmem_write = is_write_q;
    end
    if (state_q == GRANT_I) icache_mem_resp = l2_pmem_resp;
    if (state_q == GRANT_D) dcache_mem_resp = l2_pmem_resp;
  end

  assign l2_pmem_address  = addr_q;
  assign l2_pmem_wdata    = wdata_q;
  assign icache_mem_rdata = l2_pmem_rdata;
  assign dcache_mem_rdata = l2_pmem_rdata;

endmodule : pmem_scheduler
